// File: rtl/fp16_to_int.sv
// FP16 to signed integer converter: one denormalising shift per cycle,
// round-to-nearest-even, saturating with overflow/invalid flag on V.
module fp16_to_int #(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] res,
    output logic             V
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ROUND,
        DONE
    } state_t;

    localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [32:0] LIM_POS = (33'd1 << (OUT_W-1)) - 33'd1;
    localparam logic [32:0] LIM_NEG = 33'd1 << (OUT_W-1);

    state_t      state_q;
    logic        sign_q;
    logic [4:0]  exp_q;
    logic [9:0]  man_q;
    logic [16:0] mag_q;
    logic        guard_q;
    logic        sticky_q;
    logic [3:0]  cnt_q;
    logic        left_q;
    logic [OUT_W-1:0] res_q;
    logic        v_q;
    logic        valid_q;

    logic [4:0]  a_exp;
    logic [4:0]  e_eff;
    logic [10:0] sig;
    logic        left_d;
    logic [3:0]  cnt_d;
    logic [4:0]  rsh;

    assign a_exp = a[14:10];
    assign e_eff = (a_exp == 5'd0) ? 5'd1 : a_exp;
    assign sig   = {a_exp != 5'd0, a[9:0]};

    always_comb begin
        left_d = 1'b0;
        cnt_d  = 4'd0;
        rsh    = 5'd0;
        if (e_eff >= 5'd25) begin
            left_d = 1'b1;
            cnt_d  = 4'(e_eff - 5'd25);
        end else begin
            rsh   = 5'd25 - e_eff;
            cnt_d = (rsh > 5'd12) ? 4'd12 : rsh[3:0];
        end
    end

    logic [17:0] sum_d;
    logic [32:0] wide_d;
    logic [OUT_W-1:0] res_d;
    logic        v_d;

    assign sum_d  = {1'b0, mag_q}
                  + 18'(guard_q & (sticky_q | mag_q[0]));
    assign wide_d = 33'(sum_d);

    always_comb begin
        res_d = '0;
        v_d   = 1'b0;
        if (exp_q == 5'd31) begin
            v_d = 1'b1;
            if (man_q == 10'd0)
                res_d = sign_q ? MIN_NEG : MAX_POS;
        end else if (!sign_q) begin
            if (wide_d > LIM_POS) begin
                res_d = MAX_POS;
                v_d   = 1'b1;
            end else begin
                res_d = wide_d[OUT_W-1:0];
            end
        end else begin
            if (wide_d > LIM_NEG) begin
                res_d = MIN_NEG;
                v_d   = 1'b1;
            end else begin
                // Magnitude 0 negates to 0, so no negative zero appears.
                res_d = OUT_W'(-wide_d[OUT_W-1:0]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= 5'd0;
            man_q    <= 10'd0;
            mag_q    <= 17'd0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= 4'd0;
            left_q   <= 1'b0;
            res_q    <= '0;
            v_q      <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= a[15];
                        exp_q    <= a_exp;
                        man_q    <= a[9:0];
                        mag_q    <= {6'b0, sig};
                        guard_q  <= 1'b0;
                        sticky_q <= 1'b0;
                        cnt_q    <= cnt_d;
                        left_q   <= left_d;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                        if (left_q) begin
                            mag_q <= mag_q << 1;
                        end else begin
                            sticky_q <= sticky_q | guard_q;
                            guard_q  <= mag_q[0];
                            mag_q    <= mag_q >> 1;
                        end
                    end else begin
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    res_q   <= res_d;
                    v_q     <= v_d;
                    valid_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = valid_q;
    assign res       = res_q;
    assign V         = v_q;

endmodule

// File: tb/tb_fp16_to_int.sv
// Directed-vector bench for fp16_to_int at OUT_W=16, with an OUT_W=24
// instance in lockstep for the wide-result case.
module tb_fp16_to_int;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] a = 16'd0;
    logic        out_ready = 1'b0;

    logic        ir16, ov16, v16;
    logic [15:0] res16;
    logic        ir24, ov24, v24;
    logic [23:0] res24;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp16_to_int #(.OUT_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
        .a(a), .out_valid(ov16), .out_ready(out_ready),
        .res(res16), .V(v16)
    );

    fp16_to_int #(.OUT_W(24)) dut24 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir24),
        .a(a), .out_valid(ov24), .out_ready(out_ready),
        .res(res24), .V(v24)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Accept one operand and wait for out_valid; lat counts edges after accept.
    task automatic start(input logic [15:0] val, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        a = val;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'h1234;
        lat = 0;
        while (!ov16 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 40)
            chk("timeout", 32'(lat), 32'd0);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("ov_drop", {31'd0, ov16}, 32'd0);
    endtask

    task automatic conv(input string tag, input logic [15:0] val,
                        input logic [15:0] eres, input logic ev,
                        input int elat);
        int lat;
        start(val, lat);
        chk({tag, "_res"}, {16'd0, res16}, {16'd0, eres});
        chk({tag, "_v"}, {31'd0, v16}, {31'd0, ev});
        if (elat >= 0)
            chk({tag, "_lat"}, 32'(lat), 32'(elat));
        release_out();
    endtask

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ir", {31'd0, ir16}, 32'd1);
        chk("rst_ov", {31'd0, ov16}, 32'd0);
        chk("rst_res", {16'd0, res16}, 32'd0);
        chk("rst_v", {31'd0, v16}, 32'd0);

        conv("p2_5", 16'h4100, 16'd2, 1'b0, 11);
        conv("p3_5", 16'h4300, 16'd4, 1'b0, 11);
        conv("m1_5", 16'hBE00, 16'hFFFE, 1'b0, 12);
        conv("p0_5", 16'h3800, 16'd0, 1'b0, -1);
        conv("stk", 16'h3C01, 16'd1, 1'b0, -1);
        conv("dnm", 16'h0001, 16'd0, 1'b0, 14);
        conv("m32k", 16'hF800, 16'h8000, 1'b0, 7);
        conv("pinf", 16'h7C00, 16'h7FFF, 1'b1, -1);
        conv("minf", 16'hFC00, 16'h8000, 1'b1, -1);
        conv("nan", 16'h7E00, 16'd0, 1'b1, -1);
        conv("mzero", 16'h8000, 16'd0, 1'b0, -1);

        start(16'h7BFF, lat);
        chk("max_res", {16'd0, res16}, 32'h7FFF);
        chk("max_v", {31'd0, v16}, 32'd1);
        chk("w24_res", {8'd0, res24}, 32'd65504);
        chk("w24_v", {31'd0, v24}, 32'd0);
        release_out();

        start(16'h4300, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 16'h3C00;
            @(posedge clk);
            #1;
            chk("hold_res", {16'd0, res16}, 32'd4);
            chk("hold_ov", {31'd0, ov16}, 32'd1);
            chk("hold_ir", {31'd0, ir16}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out();
        chk("idle_ir", {31'd0, ir16}, 32'd1);

        @(negedge clk);
        in_valid = 1'b1;
        a = 16'h0001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_ov", {31'd0, ov16}, 32'd0);
        chk("mid_res", {16'd0, res16}, 32'd0);
        chk("mid_v", {31'd0, v16}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_ir", {31'd0, ir16}, 32'd1);
        repeat (16) @(posedge clk);
        #1;
        chk("no_ghost", {31'd0, ov16}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
